// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer.
//   WIDTH_DEFAULT : default data width in bits
//   CNT_W_DEFAULT : default width of the per-output beat counters
//   chan_e        : output channel identifier (target of a beat)
//   mode_e        : steering mode (by select bit or round-robin)
package demux_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer with a delivered-beat counter.
//   clk, rst    : clock, asynchronous active-high reset
//   wr_en       : load wr_data into the slot (only raised when can_accept)
//   wr_data     : beat to store
//   valid, data : slot contents presented to the consumer
//   ready       : consumer takes the beat this cycle
//   can_accept  : slot is empty, or full and draining this cycle
//   cnt         : beats delivered (consumer handshakes), wraps naturally
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             can_accept,
  output logic [CNT_W-1:0] cnt
);

  logic drain;

  assign drain      = valid & ready;
  // Drain and fill in the same cycle keeps one beat per cycle flowing.
  assign can_accept = ~valid | drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      cnt   <= '0;
    end else begin
      // A refill takes priority over the clear caused by a drain.
      if (wr_en) begin
        valid <= 1'b1;
        data  <= wr_data;
      end else if (drain) begin
        valid <= 1'b0;
      end
      if (drain) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/demux_1_2.sv
// Registered 1-to-2 stream demultiplexer.
//   clk, rst              : clock, asynchronous active-high reset
//   mode                  : 0 = steer by in_sel, 1 = round-robin
//   in_data/in_sel        : input beat and its target (mode 0 only)
//   in_valid/in_ready     : input handshake
//   outN_data/outN_valid  : buffered beat for output N
//   outN_ready            : consumer N takes the beat
//   cnt0/cnt1             : beats delivered on each output
//
// Handshake rule (all streams): a beat transfers on a rising edge where
// valid and ready are both high. A producer holds valid and data stable
// until the transfer; ready never depends on valid on the same stream.
module demux_1_2
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  mode_e mode_q;
  chan_e target;
  logic  rr_ptr;
  logic  acc0;
  logic  acc1;
  logic  xfer;
  logic  wr0;
  logic  wr1;

  assign mode_q = mode_e'(mode);
  assign target = (mode_q == MODE_RR) ? chan_e'(rr_ptr) : chan_e'(in_sel);

  // in_ready only reflects the targeted slot, so a stalled non-target
  // output never blocks traffic to the other one.
  assign in_ready = (target == CH0) ? acc0 : acc1;
  assign xfer     = in_valid & in_ready;
  assign wr0      = xfer & (target == CH0);
  assign wr1      = xfer & (target == CH1);

  // Pointer advances only on an accepted beat in round-robin mode, so a
  // stall or a mode switch never skips an output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (xfer && (mode_q == MODE_RR)) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  demux_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr0),
    .wr_data   (in_data),
    .valid     (out0_valid),
    .data      (out0_data),
    .ready     (out0_ready),
    .can_accept(acc0),
    .cnt       (cnt0)
  );

  demux_slot #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr1),
    .wr_data   (in_data),
    .valid     (out1_valid),
    .data      (out1_data),
    .ready     (out1_ready),
    .can_accept(acc1),
    .cnt       (cnt1)
  );

endmodule

// File: tb/tb_demux_1_2.sv
// Self-checking bench for demux_1_2: a directed vector table, a
// transaction-level reference model (one expected-beat queue per output,
// delivered-beat totals, round-robin pointer) driven by directed and
// random sequences, mid-stream reset and a counter wrap run.
module tb_demux_1_2;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             mode;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  demux_1_2 #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / reference model
  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];
  int               m_total0;
  int               m_total1;
  int               m_rr;

  function automatic void model_reset();
    exp_q0.delete();
    exp_q1.delete();
    m_total0 = 0;
    m_total1 = 0;
    m_rr     = 0;
  endfunction

  // Inputs are set at a falling edge; this samples 4 ns later (before the
  // rising edge), checks against the model, then predicts the edge.
  task automatic step();
    int  t;
    bit  exp_rdy;
    #4;
    t = mode ? m_rr : int'(in_sel);
    exp_rdy = (t == 0) ? (exp_q0.size() == 0 || out0_ready)
                       : (exp_q1.size() == 0 || out1_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out0_valid", 32'(out0_valid), 32'(exp_q0.size() != 0));
    chk("out1_valid", 32'(out1_valid), 32'(exp_q1.size() != 0));
    if (exp_q0.size() != 0) chk("out0_data", 32'(out0_data), 32'(exp_q0[0]));
    if (exp_q1.size() != 0) chk("out1_data", 32'(out1_data), 32'(exp_q1[0]));
    chk("cnt0", 32'(cnt0), 32'(m_total0 % (1 << CNT_W)));
    chk("cnt1", 32'(cnt1), 32'(m_total1 % (1 << CNT_W)));
    if (exp_q0.size() != 0 && out0_ready) begin
      void'(exp_q0.pop_front());
      m_total0++;
    end
    if (exp_q1.size() != 0 && out1_ready) begin
      void'(exp_q1.pop_front());
      m_total1++;
    end
    if (in_valid && exp_rdy) begin
      if (t == 0) exp_q0.push_back(in_data);
      else        exp_q1.push_back(in_data);
      if (mode) m_rr = 1 - m_rr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic m, input logic s, input logic [WIDTH-1:0] d,
                       input logic v, input logic r0, input logic r1);
    mode       = m;
    in_sel     = s;
    in_data    = d;
    in_valid   = v;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  // Asynchronous assert between edges, release at a falling edge.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_out0_valid"}, 32'(out0_valid), 32'd0);
    chk({tag, "_out1_valid"}, 32'(out1_valid), 32'd0);
    chk({tag, "_cnt0"}, 32'(cnt0), 32'd0);
    chk({tag, "_cnt1"}, 32'(cnt1), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // directed vector table
  typedef struct {
    logic             mode;
    logic             sel;
    logic [WIDTH-1:0] data;
    logic             vld;
    logic             r0;
    logic             r1;
    logic             rdy;
    logic             v0;
    logic [WIDTH-1:0] d0;
    logic             v1;
    logic [WIDTH-1:0] d1;
    logic [CNT_W-1:0] c0;
    logic [CNT_W-1:0] c1;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // mode sel data vld r0 r1 | rdy v0 d0 v1 d1 c0 c1  (state before the edge)
    vecs[0] = '{1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd0, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 16'd0, 16'd0};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 16'd1, 16'd0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd1, 16'd1};
    vecs[4] = '{1'b0, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd1, 16'd1};
    vecs[5] = '{1'b0, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 8'h00, 16'd1, 16'd1};
    vecs[6] = '{1'b0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h00, 16'd1, 16'd1};
    vecs[7] = '{1'b0, 1'b0, 8'hA1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b1, 8'hB0, 16'd1, 16'd1};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 8'h00, 16'd2, 16'd2};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'd3, 16'd2};

    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state, no traffic
    #4;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data", 32'(out0_data), 32'd0);
    chk("rst_out1_data", 32'(out1_data), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    @(negedge clk);

    // directed table: steering, stall, non-target bypass, in-order release
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].mode, vecs[i].sel, vecs[i].data, vecs[i].vld, vecs[i].r0, vecs[i].r1);
      #4;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_out0_valid", i), 32'(out0_valid), 32'(vecs[i].v0));
      chk($sformatf("vec%0d_out1_valid", i), 32'(out1_valid), 32'(vecs[i].v1));
      if (vecs[i].v0) chk($sformatf("vec%0d_out0_data", i), 32'(out0_data), 32'(vecs[i].d0));
      if (vecs[i].v1) chk($sformatf("vec%0d_out1_data", i), 32'(out1_data), 32'(vecs[i].d1));
      chk($sformatf("vec%0d_cnt0", i), 32'(cnt0), 32'(vecs[i].c0));
      chk($sformatf("vec%0d_cnt1", i), 32'(cnt1), 32'(vecs[i].c1));
      @(posedge clk);
      @(negedge clk);
    end

    // resync model with a clean reset
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    pulse_reset("rst2");

    // round-robin, 6 beats, both consumers ready
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b1, 1'b1);
      step();
    end
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    step();
    step();
    chk("rr6_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    chk("rr6_cnt0", 32'(cnt0), 32'd3);
    chk("rr6_cnt1", 32'(cnt1), 32'd3);

    // round-robin with out1 stalled: fourth beat must wait on out1
    pulse_reset("rst3");
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b1, WIDTH'(8'h40 + i), 1'b1, 1'b1, 1'b0);
      step();
    end
    #4;
    chk("rrstall_rr_ptr", 32'(dut.rr_ptr), 32'd1);
    chk("rrstall_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1);
      if (i > 0) in_valid = 1'b0;
      step();
    end
    chk("rrstall_q0_empty", 32'(exp_q0.size()), 32'd0);
    chk("rrstall_q1_empty", 32'(exp_q1.size()), 32'd0);

    // randomized traffic with occasional mode switches
    for (int i = 0; i < 600; i++) begin
      drive(logic'($urandom_range(0, 7) == 0 ? ~mode : mode), logic'($urandom_range(0, 1)),
            WIDTH'($urandom), logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 2) != 0));
      step();
    end

    // reset in the middle of a burst
    drive(1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 8'h5B, 1'b1, 1'b0, 1'b0);
    step();
    pulse_reset("midrst");
    chk("midrst_rr_ptr", 32'(dut.rr_ptr), 32'd0);

    // continuous stream to out0 across a counter wrap
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive(1'b0, 1'b0, WIDTH'(i), 1'b1, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step();
    chk("wrap_cnt0", 32'(cnt0), 32'd3);
    chk("wrap_cnt1", 32'(cnt1), 32'd0);
    chk("wrap_out0_valid", 32'(out0_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
